eth_rx_ctrl: RTL and testbench

RMII receive framer, the receive-side counterpart of the transmit controller. It sits between the PHY's RMII receive pins and the MAC receive datapath. It qualifies the preamble and SFD, assembles dibits LSB-first into bytes, and runs CRC-32 over every byte after the SFD. At end of carrier it reports the frame length together with CRC and error status.

---
 rtl/eth_rx_pkg.sv | 22 ++
 rtl/eth_crc32_dibit.sv | 41 ++++
 rtl/eth_rx_ctrl.sv | 173 +++++++++++++++++
 tb/tb_eth_rx_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the RMII receive framer and its CRC engine.
package eth_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DROP
  } eth_rx_ctrl_state_t;

  localparam int          pMII_WIDTH      = 2;
  localparam logic [1:0]  pPREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0]  pSFD_LAST_DIBIT = 2'b11;
  localparam logic [31:0] pCRC_INIT       = 32'hFFFFFFFF;
  localparam logic [31:0] pCRC_POLY       = 32'hEDB88320;
  localparam logic [31:0] pCRC_RESIDUE    = 32'hDEBB20E3;

  localparam int pDEF_MIN_PREAMBLE_CNT = 8;
  localparam int pDEF_MIN_FRAME_BYTES  = 64;
  localparam int pDEF_MAX_FRAME_BYTES  = 1518;

endpackage

// File: rtl/eth_crc32_dibit.sv
// Reflected CRC-32 register advanced one RMII dibit per enabled cycle.
// Din[0] is consumed first; Init has priority over En.
module eth_crc32_dibit
  import eth_rx_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Init,
  input  logic                  En,
  input  logic [pMII_WIDTH-1:0] Din,
  output logic [31:0]           Crc
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;
  logic [31:0] nxt;

  always_comb begin
    nxt = crc_q;
    for (int i = 0; i < pMII_WIDTH; i++) begin
      nxt = (nxt >> 1) ^ ((nxt[0] ^ Din[i]) ? pCRC_POLY : 32'h0);
    end
    crc_d = crc_q;
    if (Init) begin
      crc_d = pCRC_INIT;
    end else if (En) begin
      crc_d = nxt;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      crc_q <= pCRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign Crc = crc_q;

endmodule

// File: rtl/eth_rx_ctrl.sv
// RMII receive framer: preamble/SFD qualification, dibit-to-byte assembly,
// CRC-32 check and end-of-frame status reporting.
module eth_rx_ctrl
  import eth_rx_pkg::*;
#(
  parameter int pMIN_PREAMBLE_CNT = pDEF_MIN_PREAMBLE_CNT,
  parameter int pMIN_FRAME_BYTES  = pDEF_MIN_FRAME_BYTES,
  parameter int pMAX_FRAME_BYTES  = pDEF_MAX_FRAME_BYTES
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Rx_Crs_Dv,
  input  logic [pMII_WIDTH-1:0] Rxd,
  output logic [7:0]            Rx_Byte,
  output logic                  Rx_Byte_Vld,
  output logic                  Rx_Sof,
  output logic                  Rx_Done,
  output logic [10:0]           Rx_Len,
  output logic                  Rx_Crc_Ok,
  output logic                  Rx_Err
);

  eth_rx_ctrl_state_t state_q, state_d;

  logic [4:0]  pre_cnt_q, pre_cnt_d;
  logic [1:0]  dib_cnt_q, dib_cnt_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        vld_q, vld_d;
  logic        sof_q, sof_d;
  logic        done_q, done_d;
  logic [10:0] len_q, len_d;
  logic        crc_ok_q, crc_ok_d;
  logic        err_q, err_d;

  logic [31:0] crc;
  logic        sfd_hit;
  logic        byte_end;
  logic        long_hit;
  logic        crc_init;
  logic        crc_en;

  assign sfd_hit  = Rx_Crs_Dv && (Rxd == pSFD_LAST_DIBIT)
                 && (pre_cnt_q >= 5'(pMIN_PREAMBLE_CNT));
  assign byte_end = Rx_Crs_Dv && (dib_cnt_q == 2'd3);
  assign long_hit = byte_end && (byte_cnt_q == 11'(pMAX_FRAME_BYTES));
  assign crc_init = (state_q == PREAMBLE) && sfd_hit;
  assign crc_en   = (state_q == DATA) && Rx_Crs_Dv;

  eth_crc32_dibit u_crc (
    .Clk  (Clk),
    .Rst  (Rst),
    .Init (crc_init),
    .En   (crc_en),
    .Din  (Rxd),
    .Crc  (crc)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= IDLE;
      pre_cnt_q  <= '0;
      dib_cnt_q  <= '0;
      byte_cnt_q <= '0;
      shreg_q    <= '0;
      vld_q      <= 1'b0;
      sof_q      <= 1'b0;
      done_q     <= 1'b0;
      len_q      <= '0;
      crc_ok_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      dib_cnt_q  <= dib_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shreg_q    <= shreg_d;
      vld_q      <= vld_d;
      sof_q      <= sof_d;
      done_q     <= done_d;
      len_q      <= len_d;
      crc_ok_q   <= crc_ok_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (Rx_Crs_Dv) begin
          if (Rxd == pPREAMBLE_DIBIT) state_d = PREAMBLE;
          else if (Rxd != 2'b00)      state_d = DROP;
        end
      end
      PREAMBLE: begin
        if (!Rx_Crs_Dv)                   state_d = DROP;
        else if (Rxd == pPREAMBLE_DIBIT)  state_d = PREAMBLE;
        else if (sfd_hit)                 state_d = DATA;
        else                              state_d = DROP;
      end
      DATA: begin
        if (!Rx_Crs_Dv)    state_d = IDLE;
        else if (long_hit) state_d = DROP;
      end
      DROP: begin
        if (!Rx_Crs_Dv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pre_cnt_d  = pre_cnt_q;
    dib_cnt_d  = dib_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shreg_d    = shreg_q;
    vld_d      = 1'b0;
    sof_d      = 1'b0;
    done_d     = 1'b0;
    len_d      = len_q;
    crc_ok_d   = crc_ok_q;
    err_d      = err_q;
    unique case (state_q)
      IDLE: begin
        if (Rx_Crs_Dv && Rxd == pPREAMBLE_DIBIT) pre_cnt_d = 5'd1;
      end
      PREAMBLE: begin
        if (Rx_Crs_Dv && Rxd == pPREAMBLE_DIBIT && pre_cnt_q != 5'd31) begin
          pre_cnt_d = pre_cnt_q + 5'd1;
        end
        if (sfd_hit) begin
          dib_cnt_d  = '0;
          byte_cnt_d = '0;
        end
      end
      DATA: begin
        if (Rx_Crs_Dv) begin
          shreg_d   = {Rxd, shreg_q[7:2]};
          dib_cnt_d = dib_cnt_q + 2'd1;
          if (long_hit) begin
            // Oversize byte is swallowed; status is reported in its place.
            done_d   = 1'b1;
            len_d    = 11'(pMAX_FRAME_BYTES + 1);
            err_d    = 1'b1;
            crc_ok_d = 1'b0;
          end else if (byte_end) begin
            byte_cnt_d = byte_cnt_q + 11'd1;
            vld_d      = 1'b1;
            sof_d      = (byte_cnt_q == 11'd0);
          end
        end else begin
          done_d   = 1'b1;
          len_d    = byte_cnt_q;
          err_d    = (dib_cnt_q != 2'd0)
                  || (byte_cnt_q < 11'(pMIN_FRAME_BYTES));
          crc_ok_d = (crc == pCRC_RESIDUE);
        end
      end
      DROP: ;
      default: ;
    endcase
  end

  assign Rx_Byte     = shreg_q;
  assign Rx_Byte_Vld = vld_q;
  assign Rx_Sof      = sof_q;
  assign Rx_Done     = done_q;
  assign Rx_Len      = len_q;
  assign Rx_Crc_Ok   = crc_ok_q;
  assign Rx_Err      = err_q;

endmodule

// File: tb/tb_eth_rx_ctrl.sv
// Randomized frame-level bench for eth_rx_ctrl with a queue-based reference
// model of the expected byte strobes and end-of-frame reports.
module tb_eth_rx_ctrl;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Rx_Crs_Dv = 1'b0;
  logic [1:0]  Rxd = 2'b00;
  logic [7:0]  Rx_Byte;
  logic        Rx_Byte_Vld;
  logic        Rx_Sof;
  logic        Rx_Done;
  logic [10:0] Rx_Len;
  logic        Rx_Crc_Ok;
  logic        Rx_Err;

  eth_rx_ctrl dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Rx_Crs_Dv   (Rx_Crs_Dv),
    .Rxd         (Rxd),
    .Rx_Byte     (Rx_Byte),
    .Rx_Byte_Vld (Rx_Byte_Vld),
    .Rx_Sof      (Rx_Sof),
    .Rx_Done     (Rx_Done),
    .Rx_Len      (Rx_Len),
    .Rx_Crc_Ok   (Rx_Crc_Ok),
    .Rx_Err      (Rx_Err)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int         t;
    logic [7:0] b;
    logic       sof;
  } bexp_t;

  typedef struct {
    int          t;
    logic [10:0] len;
    logic        ok;
    logic        err;
  } dexp_t;

  bexp_t      bq[$];
  dexp_t      dq[$];
  logic [7:0] fb[$];

  int total = 0;
  int bad   = 0;
  int ncnt  = 0;
  int nbytes = 0;
  int nsof   = 0;
  int ndone  = 0;
  logic [10:0] last_len = '0;
  logic        last_ok  = 1'b0;
  logic        last_err = 1'b0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge Clk) begin : mon
    bexp_t be;
    dexp_t de;
    ncnt++;
    if (Rx_Byte_Vld === 1'b1) begin
      nbytes++;
      if (Rx_Sof === 1'b1) nsof++;
      if (bq.size() == 0) begin
        check("unexp_byte", 1, 0);
      end else begin
        be = bq.pop_front();
        check("byte_time", ncnt, be.t);
        check("byte_val", Rx_Byte, be.b);
        check("byte_sof", Rx_Sof, be.sof);
      end
    end else if (Rx_Sof === 1'b1) begin
      check("sof_alone", 1, 0);
    end
    if (Rx_Done === 1'b1) begin
      ndone++;
      last_len = Rx_Len;
      last_ok  = Rx_Crc_Ok;
      last_err = Rx_Err;
      check("done_vs_vld", Rx_Byte_Vld, 0);
      if (dq.size() == 0) begin
        check("unexp_done", 1, 0);
      end else begin
        de = dq.pop_front();
        check("done_time", ncnt, de.t);
        check("done_len", Rx_Len, de.len);
        check("done_ok", Rx_Crc_Ok, de.ok);
        check("done_err", Rx_Err, de.err);
      end
    end
  end

  // Bitwise reflected CRC over the first nbits of fb, LSB of each byte first.
  function automatic logic [31:0] crc_bits(input int nbits);
    logic [31:0] c;
    logic        b;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < nbits; i++) begin
      b = fb[i / 8][i % 8];
      if (c[0] ^ b) c = (c >> 1) ^ 32'hEDB88320;
      else          c = c >> 1;
    end
    return c;
  endfunction

  task automatic build(input int n);
    logic [31:0] c;
    fb.delete();
    for (int i = 0; i < n; i++) fb.push_back(8'($urandom_range(0, 255)));
    c = ~crc_bits(n * 8);
    for (int k = 0; k < 4; k++) fb.push_back(c[8*k +: 8]);
  endtask

  task automatic drive(input logic crs, input logic [1:0] d);
    Rx_Crs_Dv = crs;
    Rxd       = d;
    @(posedge Clk);
    #1;
  endtask

  task automatic run_frame(input int npre, input int bad_idx,
                           input logic [1:0] bad_val, input int ndib,
                           input int rst_at);
    bit         pre_ok;
    bit         fin;
    int         k;
    logic [1:0] d;
    pre_ok = (npre >= 8) && (bad_idx < 0);
    fin    = 1'b0;
    for (int i = 0; i < npre; i++) begin
      drive(1'b1, (i == bad_idx) ? bad_val : 2'b01);
    end
    drive(1'b1, 2'b11);
    for (int j = 0; j < ndib; j++) begin
      if (j == rst_at) begin
        Rst = 1'b1;
        drive(1'b1, 2'b10);
        Rst = 1'b0;
        fin = 1'b1;
      end else if (rst_at >= 0 && j > rst_at) begin
        drive(1'b1, 2'b10);
      end else begin
        d = fb[j / 4][(j % 4) * 2 +: 2];
        if (pre_ok && !fin && (j % 4 == 3)) begin
          k = j / 4 + 1;
          if (k <= 1518) begin
            bq.push_back('{ncnt + 2, fb[k - 1], k == 1});
          end else begin
            dq.push_back('{ncnt + 2, 11'd1519, 1'b0, 1'b1});
            fin = 1'b1;
          end
        end
        drive(1'b1, d);
      end
    end
    if (pre_ok && !fin) begin
      dq.push_back('{ncnt + 2, 11'(ndib / 4),
                     crc_bits(ndib * 2) == 32'hDEBB20E3,
                     (ndib % 4 != 0) || (ndib / 4 < 64)});
    end
    repeat (5) drive(1'b0, 2'b00);
    check("byte_drain", bq.size(), 0);
    check("done_drain", dq.size(), 0);
  endtask

  int b0, s0, d0;

  task automatic snap();
    b0 = nbytes;
    s0 = nsof;
    d0 = ndone;
  endtask

  task automatic good_frame(input string nm);
    snap();
    build(60);
    run_frame(31, -1, 2'b00, 256, -1);
    check({nm, "_bytes"}, nbytes - b0, 64);
    check({nm, "_done"}, ndone - d0, 1);
    check({nm, "_ok"}, last_ok, 1);
    check({nm, "_err"}, last_err, 0);
  endtask

  initial begin : stim
    string s;
    int    n, nd, np;
    Rst = 1'b1;
    repeat (3) drive(1'b0, 2'b00);
    check("reset_outs",
          {Rx_Byte, Rx_Byte_Vld, Rx_Sof, Rx_Done, Rx_Len, Rx_Crc_Ok, Rx_Err},
          0);
    Rst = 1'b0;
    repeat (2) drive(1'b0, 2'b00);

    s = "123456789";
    fb.delete();
    for (int i = 0; i < 9; i++) fb.push_back(s[i]);
    check("model_crc_ref", ~crc_bits(72), 32'hCBF43926);

    snap();
    build(60);
    check("model_residue", crc_bits(64 * 8), 32'hDEBB20E3);
    run_frame(31, -1, 2'b00, 256, -1);
    check("f64_bytes", nbytes - b0, 64);
    check("f64_sof", nsof - s0, 1);
    check("f64_done", ndone - d0, 1);
    check("f64_len", last_len, 64);
    check("f64_ok", last_ok, 1);
    check("f64_err", last_err, 0);

    build(60);
    fb[10] = fb[10] ^ 8'h04;
    run_frame(31, -1, 2'b00, 256, -1);
    check("flip_len", last_len, 64);
    check("flip_ok", last_ok, 0);
    check("flip_err", last_err, 0);

    build(40);
    run_frame(12, -1, 2'b00, 176, -1);
    check("runt_len", last_len, 44);
    check("runt_err", last_err, 1);
    check("runt_ok", last_ok, 1);

    build(76);
    run_frame(9, -1, 2'b00, 69 * 4 + 2, -1);
    check("align_len", last_len, 69);
    check("align_err", last_err, 1);

    snap();
    build(1526);
    run_frame(20, -1, 2'b00, 1530 * 4, -1);
    check("long_bytes", nbytes - b0, 1518);
    check("long_done", ndone - d0, 1);
    check("long_len", last_len, 1519);
    check("long_err", last_err, 1);
    check("long_ok", last_ok, 0);

    snap();
    build(60);
    run_frame(4, -1, 2'b00, 256, -1);
    check("shortpre_bytes", nbytes - b0, 0);
    check("shortpre_done", ndone - d0, 0);
    good_frame("after_shortpre");

    snap();
    build(60);
    run_frame(20, 5, 2'b10, 256, -1);
    check("badpre_bytes", nbytes - b0, 0);
    check("badpre_done", ndone - d0, 0);
    good_frame("after_badpre");

    snap();
    build(60);
    run_frame(31, -1, 2'b00, 256, 100);
    check("rst_bytes", nbytes - b0, 25);
    check("rst_done", ndone - d0, 0);
    good_frame("after_rst");

    for (int f = 0; f < 20; f++) begin
      n  = $urandom_range(30, 110);
      build(n);
      nd = fb.size() * 4;
      if ($urandom_range(0, 3) == 0) nd = nd - $urandom_range(1, 7);
      np = $urandom_range(5, 31);
      run_frame(np, -1, 2'b00, nd, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
